// File: rtl/riscv_pkg.sv
// Shared widths and control-vector field positions for the five-stage pipeline registers.
package riscv_pkg;

  localparam int CTRL_W = 10;
  localparam int CNT_W  = 16;

  // CtrlD/CtrlE = {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0]}
  localparam int REGWRITE_BIT  = 9;
  localparam int RESSRC_HI     = 8;
  localparam int RESSRC_LO     = 7;
  localparam int MEMWRITE_BIT  = 6;
  localparam int JUMP_BIT      = 5;
  localparam int BRANCH_BIT    = 4;
  localparam int ALUSRC_BIT    = 3;
  localparam int ALUCTRL_HI    = 2;
  localparam int ALUCTRL_LO    = 0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear that beats enable.
module pipe_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RESET_VAL;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipeline_regs.sv
// Inter-stage registers of a five-stage RISC-V core plus saturating stall/flush event counters.
module pipeline_regs
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  output logic [XLEN-1:0]   PCF,
  input  logic [XLEN-1:0]   InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [4:0]        RdM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  input  logic [XLEN-1:0]   ReadDataM,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [4:0]        RdW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int D_W = 3 * XLEN;
  localparam int E_W = CTRL_W + 15 + 5 * XLEN;
  localparam int M_W = 4 + 5 + 3 * XLEN;
  localparam int W_W = 3 + 5 + 3 * XLEN;

  logic [D_W-1:0] d_q;
  logic [E_W-1:0] e_q;
  logic [M_W-1:0] m_q;
  logic [W_W-1:0] w_q;

  pipe_reg #(.W(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst_n(rst_n), .en(!StallF), .clr(1'b0), .d(PCNextF), .q(PCF)
  );

  pipe_reg #(.W(D_W)) u_if_id (
    .clk(clk), .rst_n(rst_n), .en(!StallD), .clr(FlushD),
    .d({InstrF, PCF, PCPlus4F}), .q(d_q)
  );
  assign {InstrD, PCD, PCPlus4D} = d_q;

  // No stall here: a held decode is turned into a bubble by the hazard unit via FlushE.
  pipe_reg #(.W(E_W)) u_id_ex (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(FlushE),
    .d({CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D}), .q(e_q)
  );
  assign {CtrlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E} = e_q;

  pipe_reg #(.W(M_W)) u_ex_mem (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
    .d({CtrlE[REGWRITE_BIT], CtrlE[RESSRC_HI:RESSRC_LO], CtrlE[MEMWRITE_BIT],
        RdE, ALUResultE, WriteDataE, PCPlus4E}),
    .q(m_q)
  );
  assign {RegWriteM, ResultSrcM, MemWriteM, RdM, ALUResultM, WriteDataM, PCPlus4M} = m_q;

  pipe_reg #(.W(W_W)) u_mem_wb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
    .d({RegWriteM, ResultSrcM, RdM, ALUResultM, ReadDataM, PCPlus4M}), .q(w_q)
  );
  assign {RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W} = w_q;

  // A flush during a stall is the stall's own bubble, so it is not counted as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD)            StallCount <= sat_inc(StallCount);
      if (FlushE && !StallD) FlushCount <= sat_inc(FlushCount);
    end
  end

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed self-checking bench for pipeline_regs: reset, flow, stall, flush, priority, saturation.
module tb_pipeline_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, PCF, InstrF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic [9:0]  CtrlD, CtrlE;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [31:0] RD1D, RD2D, ImmExtD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [31:0] ALUResultE, WriteDataE, ALUResultM, WriteDataM, PCPlus4M;
  logic        RegWriteM, MemWriteM, RegWriteW;
  logic [1:0]  ResultSrcM, ResultSrcW;
  logic [31:0] ReadDataM, ALUResultW, ReadDataW, PCPlus4W;
  logic [15:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_regs dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .PCF(PCF),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .CtrlD(CtrlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .CtrlE(CtrlE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ReadDataM(ReadDataM), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    {StallF, StallD, FlushD, FlushE} = 4'b0;
    PCNextF = '0; InstrF = '0; PCPlus4F = '0;
    CtrlD = '0; Rs1D = '0; Rs2D = '0; RdD = '0;
    RD1D = '0; RD2D = '0; ImmExtD = '0;
    ALUResultE = '0; WriteDataE = '0; ReadDataM = '0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_pcf", PCF, 0);
    check("reset_rde", RdE, 0);
    check("reset_rdw", RdW, 0);
    check("reset_stallcnt", StallCount, 0);
    #10 rst_n = 1'b1;

    // fetch/decode flow
    PCNextF = 32'h40; InstrF = 32'h11; PCPlus4F = 32'h4;
    tick();
    check("flow_pcf0", PCF, 32'h40);
    check("flow_instrd0", InstrD, 32'h11);
    check("flow_pcd0", PCD, 32'h0);
    check("flow_pcplus4d0", PCPlus4D, 32'h4);
    PCNextF = 32'h44; InstrF = 32'h22; PCPlus4F = 32'h44;
    tick();
    check("flow_pcf1", PCF, 32'h44);
    check("flow_instrd1", InstrD, 32'h22);
    check("flow_pcd1", PCD, 32'h40);

    // RegWrite=1, ResultSrc=01, rd=5 walks through E, M, W
    CtrlD = 10'h280; RdD = 5'd5; Rs1D = 5'd3; Rs2D = 5'd4; ALUResultE = 32'h1234;
    tick();
    check("flow_rde", RdE, 5);
    check("flow_ctrle", CtrlE, 10'h280);
    check("flow_rs1e", Rs1E, 3);
    check("flow_pce", PCE, 32'h40);
    check("flow_alum", ALUResultM, 32'h1234);
    CtrlD = '0; RdD = '0; Rs1D = '0; Rs2D = '0; ReadDataM = 32'hBEEF;
    tick();
    check("flow_rdm", RdM, 5);
    check("flow_regwritem", RegWriteM, 1);
    check("flow_resultsrcm", ResultSrcM, 2'b01);
    check("flow_rde_next", RdE, 0);
    check("flow_readdataw", ReadDataW, 32'hBEEF);
    tick();
    check("flow_rdw", RdW, 5);
    check("flow_regwritew", RegWriteW, 1);
    check("flow_resultsrcw", ResultSrcW, 2'b01);
    check("flow_rdm_next", RdM, 0);

    // load-use stall: F and D hold, E gets a bubble
    PCNextF = 32'h48; InstrF = 32'h00A00093; PCPlus4F = 32'h4C;
    CtrlD = 10'h280; RdD = 5'd7;
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    tick();
    check("lu_pcf_hold", PCF, 32'h44);
    check("lu_instrd_hold", InstrD, 32'h22);
    check("lu_ctrle", CtrlE, 0);
    check("lu_rde", RdE, 0);
    check("lu_stallcnt", StallCount, 1);
    check("lu_flushcnt", FlushCount, 0);
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    tick();
    check("lu_pcf_resume", PCF, 32'h48);
    check("lu_instrd_resume", InstrD, 32'h00A00093);
    check("lu_rde_resume", RdE, 7);

    // taken branch: RdE=9 in flight, then flush D and E
    RdD = 5'd9; CtrlD = 10'h280;
    tick();
    check("br_rde_pre", RdE, 9);
    FlushD = 1'b1; FlushE = 1'b1; PCNextF = 32'h100;
    tick();
    check("br_instrd", InstrD, 0);
    check("br_pcd", PCD, 0);
    check("br_ctrle", CtrlE, 0);
    check("br_rde", RdE, 0);
    check("br_flushcnt", FlushCount, 1);
    check("br_rdm", RdM, 9);
    check("br_pcf", PCF, 32'h100);
    FlushD = 1'b0; FlushE = 1'b0; CtrlD = '0; RdD = '0;

    // flush beats stall in IF/ID
    InstrF = 32'h33; PCNextF = 32'h104;
    tick();
    check("pri_instrd_pre", InstrD, 32'h33);
    FlushD = 1'b1; StallD = 1'b1; InstrF = 32'h44;
    tick();
    check("pri_instrd", InstrD, 0);
    check("pri_pcd", PCD, 0);
    check("pri_stallcnt", StallCount, 2);
    FlushD = 1'b0; StallD = 1'b0;

    // StallF and FlushE together act independently
    CtrlD = 10'h3FF; RdD = 5'd12; PCNextF = 32'h200;
    StallF = 1'b1; FlushE = 1'b1;
    tick();
    check("sf_fe_pcf", PCF, 32'h104);
    check("sf_fe_ctrle", CtrlE, 0);
    check("sf_fe_flushcnt", FlushCount, 2);
    StallF = 1'b0; FlushE = 1'b0;
    tick();
    check("sf_fe_ctrle_next", CtrlE, 10'h3FF);
    tick();
    check("nopass_memwrite", MemWriteM, 1);
    CtrlD = '0; RdD = '0;

    // asynchronous reset mid-cycle
    PCNextF = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    check("ar_pcf", PCF, 0);
    check("ar_rde", RdE, 0);
    check("ar_rdm", RdM, 0);
    check("ar_rdw", RdW, 0);
    check("ar_stallcnt", StallCount, 0);
    check("ar_flushcnt", FlushCount, 0);
    #1 rst_n = 1'b1;
    #1;
    check("ar_pcf_before_edge", PCF, 0);
    tick();
    check("ar_pcf_first_edge", PCF, 32'h40);

    // StallCount saturation
    StallD = 1'b1;
    repeat (65534) tick();
    check("sat_almost", StallCount, 16'hFFFE);
    tick();
    check("sat_full", StallCount, 16'hFFFF);
    repeat (5) tick();
    check("sat_nowrap", StallCount, 16'hFFFF);
    check("sat_flushcnt", FlushCount, 0);
    StallD = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
Parameters:
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PCF value after reset.
Ports (name  direction  width  meaning):
REQ-003 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have StallF, StallD, FlushD, FlushE  in  1 each  hazard-control inputs.
REQ-006 SHALL have PCNextF  in  XLEN  next PC; PCF  out  XLEN  fetch PC.
REQ-007 SHALL have InstrF, PCPlus4F  in  XLEN; InstrD, PCD, PCPlus4D  out  XLEN  IF/ID stage.
REQ-008 SHALL have CtrlD  in  10  decode control vector {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0]}.
REQ-009 SHALL have Rs1D, Rs2D, RdD  in  5; RD1D, RD2D, ImmExtD  in  XLEN  decode operands.
REQ-010 SHALL have CtrlE  out  10; Rs1E, Rs2E, RdE  out  5; RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  ID/EX stage.
REQ-011 SHALL have ALUResultE, WriteDataE  in  XLEN; ALUResultM, WriteDataM, PCPlus4M  out  XLEN; RdM  out  5; RegWriteM, MemWriteM  out  1; ResultSrcM  out  2  EX/MEM stage.
REQ-012 SHALL have ReadDataM  in  XLEN; ALUResultW, ReadDataW, PCPlus4W  out  XLEN; RdW  out  5; RegWriteW  out  1; ResultSrcW  out  2  MEM/WB stage.
REQ-013 SHALL have StallCount, FlushCount  out  16 each  saturating event counters.

Function
REQ-014 PCF SHALL load PCNextF each cycle unless StallF=1, in which case it holds.
REQ-015 IF/ID SHALL, in priority order: FlushD=1 -> clear InstrD, PCD, PCPlus4D to 0; else StallD=1 -> hold; else load InstrF, PCF, PCPlus4F.
REQ-016 ID/EX SHALL load all D-side fields every cycle unless FlushE=1, in which case every E-side output (CtrlE, Rs1E, Rs2E, RdE, data) is cleared to 0 (bubble).
REQ-017 ID/EX SHALL have no stall input; a stalled decode re-enters as a bubble via FlushE.
REQ-018 EX/MEM and MEM/WB SHALL advance unconditionally every cycle; latency of each stage is exactly one cycle.
REQ-019 RegWriteM/W, ResultSrcM/W, MemWriteM SHALL be the corresponding CtrlE fields delayed one/two cycles; Jump, Branch, ALUSrc, ALUControl SHALL not propagate past E.
REQ-020 Simultaneous FlushD=1 and StallD=1: flush SHALL win; simultaneous StallF=1 and FlushE=1: both SHALL take effect independently.
REQ-021 StallCount SHALL increment when StallD=1, FlushCount SHALL increment when FlushE=1 and StallD=0; both saturate at 16'hFFFF without wrap.
REQ-022 Rs1E, Rs2E, RdE, ResultSrcE (CtrlE[8:7]), RdM, RegWriteM, RdW, RegWriteW SHALL be driven directly from flops (no combinational path from any input).

Reset
REQ-023 rst_n=0 SHALL immediately set PCF=RESET_PC and all other outputs, including counters, to 0, independent of clk.
REQ-024 Deassertion SHALL take effect on the first rising clk edge with rst_n=1; reset mid-operation discards all in-flight instructions.

Structure
REQ-025 Control-vector width, field bit positions, and counter width SHALL be localparams in shared package riscv_pkg.
REQ-026 A single sub-module pipe_reg (parameterised width, enable, synchronous clear, async active-low reset) SHALL be instantiated per stage; counters live in the top module.

Verification
REQ-027 Reset: rst_n=0 mid-cycle with PCNextF=0x40 -> PCF=0x0, RdE=RdM=RdW=0, counters 0 before next edge.
REQ-028 Load-use: StallF=StallD=FlushE=1 one cycle, InstrF=0x00A00093 -> PCF and InstrD hold, CtrlE=0, RdE=0, StallCount=1.
REQ-029 Taken branch: FlushD=FlushE=1 one cycle -> InstrD=0, CtrlE=0, FlushCount=1, RdM still carries prior RdE.
REQ-030 Pipeline flow: RdD=5 with RegWrite=1 -> RdE=5 after 1 cycle, RdM=5/RegWriteM=1 after 2, RdW=5/RegWriteW=1 after 3.
REQ-031 Priority: FlushD=1 and StallD=1 together -> InstrD=0, PCD=0.
REQ-032 Saturation: StallD=1 held 65540 cycles -> StallCount=16'hFFFF, no wrap.
